bus_slave_port: RTL

Slave-side responder of the serial system bus. It terminates the bit-serial frames that master ports emit on behalf of the d1/d2 device interfaces, decodes address, mode and write data, and accesses a local byte memory. For reads it returns data bit-serially to the bus. One instance sits behind each slave select of the bus interconnect.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/slave_bram.sv | 22 ++
 rtl/bus_slave_port.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: FSM encoding, mode values, default widths.
// Reused by the slave responder and the master-side blocks.
package bus_pkg;

  localparam int BUS_ADDR_WIDTH           = 16;
  localparam int BUS_DATA_WIDTH           = 8;
  localparam int BUS_SLAVE_MEM_ADDR_WIDTH = 12;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_MEMRD,
    S_RLOAD,
    S_RDATA
  } state_t;

endpackage

// File: rtl/slave_bram.sv
// Single-port synchronous RAM with a registered read port.
// Write and read share one address; q reflects the previous edge's address.
module slave_bram #(
  parameter int AW    = 12,
  parameter int DW    = 8,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/bus_slave_port.sv
// Slave responder of the serial bus: deserialises address/mode/write data,
// accesses the local byte memory and serialises read data back, LSB first.
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int SLAVE_MEM_ADDR_WIDTH = BUS_SLAVE_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH           = BUS_DATA_WIDTH,
  parameter int MEM_DEPTH            = 2 ** SLAVE_MEM_ADDR_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic s_valid,
  input  logic s_mode,
  input  logic s_wdata,
  output logic s_ready,
  output logic s_rdata,
  output logic s_rvalid,
  output logic done
);

  localparam int AW   = SLAVE_MEM_ADDR_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int MAXW = (AW > DW) ? AW : DW;
  localparam int CW   = $clog2(MAXW) + 1;

  localparam logic [CW-1:0] A_LAST = CW'(AW - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] D_END  = CW'(DW);

  state_t        state;
  state_t        next;
  logic          mode;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [DW-1:0] shreg;
  logic [DW-1:0] q;

  assign s_ready = (state == S_IDLE);

  slave_bram #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (state == S_WRITE),
    .addr  (addr),
    .wdata (data),
    .q     (q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:  if (s_valid) next = S_ADDR;
      S_ADDR: begin
        if (!s_valid)
          next = S_IDLE;
        else if (cnt == A_LAST)
          next = (mode == MODE_WRITE) ? S_WDATA : S_MEMRD;
      end
      S_WDATA: begin
        if (!s_valid)           next = S_IDLE;
        else if (cnt == D_LAST) next = S_WRITE;
      end
      S_WRITE: next = S_IDLE;
      S_MEMRD: next = S_RLOAD;
      S_RLOAD: next = S_RDATA;
      S_RDATA: if (cnt == D_END) next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  // Serial fields arrive LSB first, so shift right from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= MODE_READ;
      cnt      <= '0;
      s_rdata  <= 1'b0;
      s_rvalid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (s_valid) begin
            mode <= s_mode;
            addr <= {s_wdata, addr[AW-1:1]};
            cnt  <= CW'(1);
          end
        end
        S_ADDR: begin
          if (!s_valid) begin
            cnt <= '0;
          end else begin
            addr <= {s_wdata, addr[AW-1:1]};
            cnt  <= (cnt == A_LAST) ? '0 : cnt + 1'b1;
          end
        end
        S_WDATA: begin
          if (!s_valid) begin
            cnt <= '0;
          end else begin
            data <= {s_wdata, data[DW-1:1]};
            if (cnt == D_LAST) begin
              cnt  <= '0;
              done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_RLOAD: begin
          shreg    <= q;
          s_rdata  <= q[0];
          s_rvalid <= 1'b1;
          cnt      <= '0;
        end
        S_RDATA: begin
          if (cnt == D_END) begin
            cnt <= '0;
          end else if (cnt == D_LAST) begin
            s_rvalid <= 1'b0;
            s_rdata  <= 1'b0;
            done     <= 1'b1;
            cnt      <= D_END;
          end else begin
            shreg   <= shreg >> 1;
            s_rdata <= shreg[1];
            cnt     <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
